fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, giving the entry width (u32 raw instruction plus u64 pc).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous redirect (branch or CSR flush) that discards all entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the producer (fetch) offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the queue accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: the fetched entry.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds the oldest entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer (decode) takes out_data.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: the oldest entry.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1) bits: the number of stored entries.

Function
REQ-013 A push SHALL occur in a cycle where in_valid and in_ready are both high; a pop SHALL occur where out_valid and out_ready are both high.
REQ-014 in_ready SHALL equal (count != DEPTH) and not flush; it SHALL NOT depend combinationally on out_ready.
REQ-015 out_valid SHALL equal (count != 0) and not flush, except for the bypass case in REQ-028.
REQ-016 out_data SHALL be the entry at the read pointer; when out_valid is low its value is don't-care.
REQ-017 Entries SHALL leave in strict FIFO order.
REQ-018 Without bypass, push-to-out_valid latency SHALL be exactly 1 cycle.
REQ-019 The write and read pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-020 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 When full, a push SHALL NOT be possible; a pop while full SHALL lower count to DEPTH-1, and in_ready SHALL rise the next cycle.
REQ-022 When empty, a pop SHALL NOT be possible, and count SHALL never underflow or overflow.
REQ-023 flush high at a clock edge SHALL set both pointers and count to 0, overriding any push or pop in that cycle.
REQ-024 The storage array SHALL NOT be reset or cleared by flush; only pointers and count define validity.

Reset
REQ-025 Asserting reset SHALL immediately, without a clock edge, set the write pointer, read pointer and count to 0.
REQ-026 During reset, in_ready SHALL be 1 (unless flush is high), out_valid SHALL be 0 and count SHALL be 0; reset asserted mid-operation discards all entries.
REQ-027 The first push after reset deasserts SHALL be accepted on the first rising edge with in_valid high.

Configuration
REQ-028 With macro FETCH_QUEUE_BYPASS_EN defined, when count == 0, in_valid is high and flush is low, out_valid SHALL be 1 and out_data SHALL be in_data combinationally. If out_ready is also high, the entry SHALL be consumed without being written and count SHALL stay 0; otherwise it SHALL be written normally.
REQ-029 With FETCH_QUEUE_BYPASS_EN undefined, no combinational in-to-out path SHALL exist, and REQ-015 and REQ-018 apply unconditionally.

Verification
REQ-030 Reset, then push 4 entries (pc 0x80000000, +4, +8, +C) with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted.
REQ-031 From full, set out_ready=1 for 4 cycles -> pcs 0x80000000..0x8000000C pop in order, count=0, out_valid=0, in_ready=1 from the first pop onward.
REQ-032 With count=2, push and pop every cycle for 10 cycles -> count stays 2, order is preserved, and the pointers wrap at least twice.
REQ-033 With count=3, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, and the flush-cycle in_data is not stored.
REQ-034 Assert reset asynchronously between edges with count=2 -> count=0 and out_valid=0 before the next edge.
REQ-035 With FETCH_QUEUE_BYPASS_EN defined, empty queue, in_valid=1, out_ready=1, in_data pc 0x80000010 -> out_valid=1 and out_data=in_data in the same cycle, and count stays 0; without the macro, out_valid rises the next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: DEPTH-entry FIFO with flush.
// Optional same-cycle empty-queue bypass under macro FETCH_QUEUE_BYPASS_EN.

module fq_entry #(
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // Payload is never reset; validity comes only from the queue pointers.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module fetch_queue #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             cnt;
  logic [DEPTH-1:0][DATA_W-1:0] ent_q;
  logic [DEPTH-1:0]             ent_we;
  logic empty, full, push, pop, wr_en, rd_en, byp_take;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign in_ready = !full && !flush;
  assign count    = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp_hit;
  assign byp_hit   = empty && in_valid && !flush;
  assign out_valid = (!empty && !flush) || byp_hit;
  assign out_data  = empty ? in_data : ent_q[rd_ptr];
  assign byp_take  = byp_hit && out_ready;
`else
  assign out_valid = !empty && !flush;
  assign out_data  = ent_q[rd_ptr];
  assign byp_take  = 1'b0;
`endif

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  // A bypassed entry is consumed straight from in_data and never touches storage.
  assign wr_en = push && !byp_take;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_we[g] = wr_en && (wr_ptr == PTR_W'(g));
    fq_entry #(.DATA_W(DATA_W)) u_ent (
      .clk (clk),
      .we  (ent_we[g]),
      .d   (in_data),
      .q   (ent_q[g])
    );
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, streaming wrap, flush, async reset, bypass.
// Expectations follow the FETCH_QUEUE_BYPASS_EN setting of the build.

module tb_fetch_queue;
  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [95:0] in_data, out_data;
  logic [2:0]  count;

  int nvec = 0;
  int nerr = 0;

  fetch_queue dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [95:0] mk(input logic [63:0] pc);
    return {32'h00000013, pc};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [95:0] exp_q[$];
  logic [63:0] pc;

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    #3;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    #9 reset = 0;

    // Fill to full with out_ready low; first push lands on first edge.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data  = mk(64'h80000000 + 64'(4*i));
      tick();
      check("fill_count", count, 128'(i+1));
    end
    check("full_in_ready", in_ready, 0);
    in_data = mk(64'h80000010);
    tick();
    check("full_no_push_count", count, 4);
    check("full_head", out_data, mk(64'h80000000));

    // Drain in order.
    in_valid = 0; out_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, mk(64'h80000000 + 64'(4*i)));
      tick();
      check("drain_count", count, 128'(3-i));
      check("drain_in_ready", in_ready, 1);
    end
    check("empty_out_valid", out_valid, 0);

    // Prime to two entries, then stream push+pop for 10 cycles.
    out_ready = 0; pc = 64'h90000000;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = mk(pc); exp_q.push_back(mk(pc)); pc += 4;
      tick();
    end
    check("prime_count", count, 2);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; out_ready = 1; in_data = mk(pc); exp_q.push_back(mk(pc)); pc += 4;
      #1;
      check("stream_data", out_data, exp_q.pop_front());
      tick();
      check("stream_count", count, 2);
    end

    // Third entry, then flush with push and pop both offered.
    out_ready = 0; in_data = mk(pc); exp_q.push_back(mk(pc)); pc += 4;
    tick();
    check("pre_flush_count", count, 3);
    flush = 1; in_valid = 1; out_ready = 1; in_data = mk(64'hDEAD0000);
    #1;
    check("flush_in_ready", in_ready, 0);
    check("flush_out_valid", out_valid, 0);
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    #1;
    check("post_flush_count", count, 0);
    check("post_flush_out_valid", out_valid, 0);
    in_valid = 1; in_data = mk(64'hA0000000);
    tick();
    in_data = mk(64'hA0000004);
    check("post_flush_head", out_data, mk(64'hA0000000));
    tick();
    in_valid = 0;
    check("pre_reset_count", count, 2);

    // Async reset between edges.
    #3 reset = 1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    #2 reset = 0;

    // Empty queue, push with consumer ready.
    in_valid = 1; out_ready = 1; in_data = mk(64'h80000010);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_out_valid", out_valid, 1);
    check("byp_out_data", out_data, mk(64'h80000010));
    tick();
    in_valid = 0;
    check("byp_count", count, 0);
`else
    check("nobyp_out_valid", out_valid, 0);
    tick();
    in_valid = 0;
    #1;
    check("nobyp_count", count, 1);
    check("nobyp_next_valid", out_valid, 1);
    check("nobyp_next_data", out_data, mk(64'h80000010));
    tick();
    check("nobyp_drain_count", count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
